// File: rtl/spi_master_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_cfg
//  Purpose  : Full-duplex SPI master for DATA_W-bit words. Supports all four
//             CPOL/CPHA modes, a programmable SCLK half-period
//             (H = clk_div + 1 clk cycles), MSB- or LSB-first bit order and
//             NUM_SS one-hot active-low slave selects.
//  Ports    : clk, rst_n      - system clock, async active-low reset
//             start           - transfer request, honoured only while idle
//             tx_data, ss_sel, cpol, cpha, lsb_first, clk_div
//                             - per-transfer configuration, captured on start
//             busy, done      - transfer in progress / 1-cycle completion pulse
//             rx_data         - last received word, valid from done onwards
//             sclk, mosi, miso, ss_n
//                             - SPI bus (sclk, mosi and ss_n are registered)
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_cfg #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8,
    parameter int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int c_CNT_W = $clog2(2 * DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_EDGE = c_CNT_W'(2 * DATA_W);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SETUP = 2'd1;
    localparam logic [1:0] c_XFER  = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    logic [1:0]         r_state;
    logic [DIV_W-1:0]   r_hcnt;
    logic [DIV_W-1:0]   r_div;
    logic [c_CNT_W-1:0] r_edge;
    logic [DATA_W-1:0]  r_tx_sh;
    logic [DATA_W-1:0]  r_rx_sh;
    logic               r_cpha;
    logic               r_lsb;

    logic [c_CNT_W-1:0] w_edge_nxt;
    logic               w_lead;
    logic               w_sample;
    logic [DATA_W-1:0]  w_tx_shift;
    logic [DATA_W-1:0]  w_rx_nxt;
    logic               w_cur_bit;
    logic               w_nxt_bit;
    logic               w_first_bit;
    logic [NUM_SS-1:0]  w_ss_dec;

    // Edge about to be issued; odd numbers are leading edges.
    assign w_edge_nxt = r_edge + c_CNT_W'(1);
    assign w_lead     = w_edge_nxt[0];
    assign w_sample   = r_cpha ? ~w_lead : w_lead;

    // The outgoing bit always sits at the "exit" end of the shift register.
    assign w_tx_shift  = r_lsb ? (r_tx_sh >> 1) : (r_tx_sh << 1);
    assign w_cur_bit   = r_lsb ? r_tx_sh[0]    : r_tx_sh[DATA_W-1];
    assign w_nxt_bit   = r_lsb ? w_tx_shift[0] : w_tx_shift[DATA_W-1];
    assign w_first_bit = lsb_first ? tx_data[0] : tx_data[DATA_W-1];

    // Shifting in from the far end places receive bit k at the same index
    // the corresponding transmit bit came from.
    assign w_rx_nxt = r_lsb ? {miso, r_rx_sh[DATA_W-1:1]}
                            : {r_rx_sh[DATA_W-2:0], miso};

    // Out-of-range selects match no line, so every slave stays deselected.
    always_comb begin
        w_ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (ss_sel == SEL_W'(i)) begin
                w_ss_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_hcnt  <= '0;
            r_div   <= '0;
            r_edge  <= '0;
            r_tx_sh <= '0;
            r_rx_sh <= '0;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            ss_n    <= '1;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    sclk <= cpol;
                    if (start) begin
                        r_state <= c_SETUP;
                        r_hcnt  <= clk_div;
                        r_div   <= clk_div;
                        r_edge  <= '0;
                        r_tx_sh <= tx_data;
                        r_cpha  <= cpha;
                        r_lsb   <= lsb_first;
                        busy    <= 1'b1;
                        ss_n    <= w_ss_dec;
                        // Mode with sampling on the leading edge needs the
                        // first bit on the wire before that edge.
                        if (!cpha) begin
                            mosi <= w_first_bit;
                        end
                    end
                end
                // SETUP expiry issues edge 1, so it shares the edge logic.
                c_SETUP, c_XFER: begin
                    if (r_hcnt == '0) begin
                        r_hcnt <= r_div;
                        r_edge <= w_edge_nxt;
                        sclk   <= ~sclk;
                        if (w_sample) begin
                            r_rx_sh <= w_rx_nxt;
                        end
                        if (r_cpha && w_lead) begin
                            mosi    <= w_cur_bit;
                            r_tx_sh <= w_tx_shift;
                        end else if (!r_cpha && !w_lead && (w_edge_nxt != c_LAST_EDGE)) begin
                            mosi    <= w_nxt_bit;
                            r_tx_sh <= w_tx_shift;
                        end
                        r_state <= (w_edge_nxt == c_LAST_EDGE) ? c_HOLD : c_XFER;
                    end else begin
                        r_hcnt <= r_hcnt - DIV_W'(1);
                    end
                end
                c_HOLD: begin
                    if (r_hcnt == '0) begin
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        ss_n    <= '1;
                        rx_data <= r_rx_sh;
                    end else begin
                        r_hcnt <= r_hcnt - DIV_W'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_cfg
//  Purpose  : Self-checking bench for spi_master_cfg. A transaction-level
//             model (edge index = elapsed cycles / H) predicts busy, done,
//             ss_n, sclk, mosi and rx_data every cycle; a slave model drives
//             miso only right before the expected sampling edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_cfg;

    localparam int N   = 8;
    localparam int NSS = 4;
    localparam int DW  = 8;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b1;
    logic           start     = 1'b0;
    logic [N-1:0]   tx_data   = '0;
    logic [1:0]     ss_sel    = '0;
    logic           cpol      = 1'b0;
    logic           cpha      = 1'b0;
    logic           lsb_first = 1'b0;
    logic [DW-1:0]  clk_div   = '0;
    logic           miso      = 1'b0;
    logic           busy;
    logic           done;
    logic [N-1:0]   rx_data;
    logic           sclk;
    logic           mosi;
    logic [NSS-1:0] ss_n;

    spi_master_cfg #(.DATA_W(N), .NUM_SS(NSS), .DIV_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .ss_sel(ss_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .clk_div(clk_div), .busy(busy), .done(done), .rx_data(rx_data),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus-side expectations and slave word
    logic [N-1:0]   s_word   = '0;
    int             exp_lat  = 0;
    bit             exp_rx_v = 1'b0;
    logic [N-1:0]   exp_rx   = '0;
    bit             exp_ss_v = 1'b0;
    logic [NSS-1:0] exp_ss   = '1;

    // Model state
    bit           m_active = 1'b0;
    int           m_t = 0, m_h = 1, m_d = 0, m_sel = 0, cyc = 0, m_acc = 0;
    logic [N-1:0] m_tx = '0, m_slave = '0, m_rx = '0;
    bit           m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic txbit(input int j);
        return m_lsb ? m_tx[j] : m_tx[N-1-j];
    endfunction

    // Model update on each edge, then compare shortly after it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_rx     = '0;
            #1;
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_done", 32'(done), 32'(0));
            chk("rst_sclk", 32'(sclk), 32'(0));
            chk("rst_mosi", 32'(mosi), 32'(0));
            chk("rst_ss_n", 32'(ss_n), 32'(4'hF));
            chk("rst_rx",   32'(rx_data), 32'(m_rx));
        end else begin
            int k, j;
            bit b, es_clk;
            logic [NSS-1:0] es;
            cyc++;
            if (m_active && m_t < m_d) begin
                m_t++;
            end else if (start) begin
                m_active = 1'b1; m_t = 0; m_acc = cyc;
                m_tx = tx_data; m_sel = int'(ss_sel); m_cpol = cpol; m_cpha = cpha;
                m_lsb = lsb_first; m_slave = s_word;
                m_h = int'(clk_div) + 1;
                m_d = (2 * N + 1) * m_h;
            end else begin
                m_active = 1'b0;
            end
            if (m_active && m_t == m_d) m_rx = m_slave;
            #1;
            b = m_active && (m_t < m_d);
            chk("busy", 32'(busy), 32'(b));
            chk("done", 32'(done), 32'(m_active && (m_t == m_d)));
            es = '1;
            if (b && m_sel < NSS) es[m_sel] = 1'b0;
            chk("ss_n", 32'(ss_n), 32'(es));
            if (m_active) begin
                k = m_t / m_h;
                if (k > 2 * N) k = 2 * N;
                es_clk = m_cpol ^ (k % 2 == 1);
            end else begin
                es_clk = cpol;
            end
            chk("sclk", 32'(sclk), 32'(es_clk));
            chk("rx_data", 32'(rx_data), 32'(m_rx));
            // mosi must carry bit j just before the slave's sampling edge
            if (b && ((m_t + 1) % m_h == 0)) begin
                k = (m_t + 1) / m_h;
                if (m_cpha ? (k % 2 == 0 && k <= 2 * N) : (k % 2 == 1 && k < 2 * N)) begin
                    j = m_cpha ? (k / 2 - 1) : ((k - 1) / 2);
                    chk("mosi", 32'(mosi), 32'(txbit(j)));
                end
            end
            if (m_active && m_t == m_d) chk("mosi_hold", 32'(mosi), 32'(txbit(N-1)));
            if (b && exp_ss_v) chk("ss_n_lit", 32'(ss_n), 32'(exp_ss));
            if (done === 1'b1 && exp_lat != 0) chk("latency", 32'(cyc - m_acc), 32'(exp_lat));
            if (done === 1'b1 && exp_rx_v) chk("rx_lit", 32'(rx_data), 32'(exp_rx));
        end
    end

    // Advance to the next negedge and present the slave's miso for the coming edge.
    task automatic tick();
        int tn, k, j;
        logic v;
        @(negedge clk);
        v = 1'($urandom_range(0, 1));
        if (m_active && m_t < m_d) begin
            tn = m_t + 1;
            if (tn % m_h == 0) begin
                k = tn / m_h;
                if (k <= 2 * N && (m_cpha ? (k % 2 == 0) : (k % 2 == 1))) begin
                    j = m_cpha ? (k / 2 - 1) : ((k - 1) / 2);
                    v = m_slave[m_lsb ? j : N-1-j];
                end
            end
        end
        miso = v;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (m_active && m_t < m_d) begin
            tick();
            n++;
            if (n > 20000) begin
                $display("FAIL wait_ready: got timeout expected transfer end");
                $fatal(1, "bench stalled");
            end
        end
    endtask

    task automatic xfer(input logic [N-1:0] tx, input int sel, input bit pol, input bit pha,
                        input bit lsb, input int div, input logic [N-1:0] sw, input int lat,
                        input bit rxv, input logic [N-1:0] rxe, input bit ssv,
                        input logic [NSS-1:0] sse);
        wait_ready();
        tx_data = tx; ss_sel = 2'(sel); cpol = pol; cpha = pha; lsb_first = lsb;
        clk_div = DW'(div); s_word = sw;
        exp_lat = lat; exp_rx_v = rxv; exp_rx = rxe; exp_ss_v = ssv; exp_ss = sse;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Configuration was captured; these changes must not disturb the transfer.
        tx_data = N'($urandom); ss_sel = 2'($urandom_range(0, 3));
        cpha = 1'($urandom_range(0, 1)); lsb_first = 1'($urandom_range(0, 1));
        clk_div = DW'($urandom_range(0, 7));
        wait_ready();
        tick();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Mode 0 loopback
        xfer(8'hA5, 0, 0, 0, 0, 1, 8'hA5, 34, 1, 8'hA5, 1, 4'b1110);
        // Modes 1..3, slave returns 0x3C
        xfer(N'($urandom), 1, 0, 1, 0, 2, 8'h3C, 51, 1, 8'h3C, 1, 4'b1101);
        xfer(N'($urandom), 2, 1, 0, 0, 2, 8'h3C, 51, 1, 8'h3C, 1, 4'b1011);
        xfer(N'($urandom), 3, 1, 1, 0, 2, 8'h3C, 51, 1, 8'h3C, 1, 4'b0111);
        // LSB first, fastest SCLK
        xfer(8'h01, 0, 0, 0, 1, 0, 8'hC3, 17, 1, 8'hC3, 0, 4'hF);

        // start held high, tx changed mid-transfer, back-to-back in the done cycle
        wait_ready();
        tx_data = 8'h5A; ss_sel = 2'd3; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        clk_div = 8'd1; s_word = 8'h99;
        exp_lat = 34; exp_rx_v = 1'b1; exp_rx = 8'h99; exp_ss_v = 1'b1; exp_ss = 4'b0111;
        start = 1'b1;
        tick();
        tx_data = 8'hFF;
        for (int n = 0; n < 200 && !(m_active && m_t == m_d); n++) tick();
        s_word = 8'h42; exp_rx = 8'h42;
        tick();
        start = 1'b0;
        wait_ready();
        tick();

        // Reset after sclk edge 5 of a transfer
        wait_ready();
        exp_lat = 0; exp_rx_v = 1'b0; exp_ss_v = 1'b0;
        tx_data = 8'h33; ss_sel = 2'd1; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0;
        clk_div = 8'd1; s_word = 8'h77;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 100 && !(m_active && m_t >= 5 * m_h); n++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Slowest SCLK
        xfer(N'($urandom), 2, 1, 1, 0, 255, 8'h5C, 17 * 256, 1, 8'h5C, 1, 4'b1011);

        // Randomized transfers
        for (int r = 0; r < 16; r++) begin
            xfer(N'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), N'($urandom), 0, 0, '0, 0, '1);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
